// File: rtl/uart_fifo_pkg.sv
// Shared UART FIFO sizing constants and the per-cycle FIFO operation encoding.
// The same defaults size the ALU UART interface and the UART RX/TX FIFO instances.
package uart_fifo_pkg;

  localparam int UART_NB_DATA = 8;
  localparam int UART_NB_ADDR = 4;

  // Per-cycle accepted operation, encoded as {write_accepted, read_accepted}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: NB_DATA x 2**NB_ADDR register array, synchronous write port,
// asynchronous read port. Pointer and occupancy control live in uart_fifo.
module uart_fifo_mem #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 4
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data
);

  localparam int DEPTH = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] mem [DEPTH];

  // NOTE: no reset on the array; contents are unobservable until written, and
  // leaving it unreset keeps it mappable to plain flops or distributed RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO used on each direction of the UART link.
// Occupancy is tracked by a count register; flags and error pulses are registered.
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int NB_DATA = UART_NB_DATA,
  parameter int NB_ADDR = UART_NB_ADDR
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_write,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic               i_read,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_empty,
  output logic               o_full,
  output logic [NB_ADDR:0]   o_count,
  output logic               o_overflow,
  output logic               o_underflow
);

  localparam int             DEPTH      = 2 ** NB_ADDR;
  localparam logic [NB_ADDR:0] COUNT_FULL = (NB_ADDR + 1)'(DEPTH);

  logic [NB_ADDR-1:0] wr_ptr, rd_ptr;
  logic [NB_ADDR:0]   count, count_next;
  logic               empty, full;
  logic               overflow, underflow;
  logic               rd_acc, wr_acc;
  fifo_op_e           op;
  logic [NB_DATA-1:0] mem_rd_data;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign rd_acc = i_read && !empty;
  assign wr_acc = i_write && (!full || rd_acc);
  assign op     = fifo_op_e'({wr_acc, rd_acc});

  // NOTE: default assigned first so every path drives count_next; no latch.
  always_comb begin
    count_next = count;
    case (op)
      OP_PUSH: count_next = count + 1'b1;
      OP_POP:  count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      empty     <= (count_next == '0);
      full      <= (count_next == COUNT_FULL);
      overflow  <= i_write && full && !rd_acc;
      underflow <= i_read && empty;
    end
  end

  // Writes issued during reset must not disturb storage either.
  uart_fifo_mem #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_mem (
    .i_clk     (i_clk),
    .i_we      (wr_acc && i_reset_n),
    .i_wr_addr (wr_ptr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (rd_ptr),
    .o_rd_data (mem_rd_data)
  );

  assign o_rd_data   = empty ? '0 : mem_rd_data;
  assign o_empty     = empty;
  assign o_full      = full;
  assign o_count     = count;
  assign o_overflow  = overflow;
  assign o_underflow = underflow;

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: a vector table plus hand-written corner
// sequences, with a queue scoreboard holding the words expected on pop.
module tb_uart_fifo;

  localparam int DEPTH = 16;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_write;
  logic [7:0] i_wr_data;
  logic       i_read;
  logic [7:0] o_rd_data;
  logic       o_empty;
  logic       o_full;
  logic [4:0] o_count;
  logic       o_overflow;
  logic       o_underflow;

  uart_fifo dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_write     (i_write),
    .i_wr_data   (i_wr_data),
    .i_read      (i_read),
    .o_rd_data   (o_rd_data),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb_q[$];
  int         m_count   = 0;
  logic       m_ovf     = 1'b0;
  logic       m_udf     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check the popped head word at the falling edge,
  // advance the model, then check registered outputs just after the rising edge.
  task automatic do_cycle(input logic rst_n, input logic wr, input logic [7:0] d,
                          input logic rd);
    logic rd_ok, wr_ok;
    i_reset_n = rst_n;
    i_write   = wr;
    i_wr_data = d;
    i_read    = rd;
    @(negedge i_clk);
    if (!rst_n) begin
      sb_q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      rd_ok = rd && (m_count != 0);
      wr_ok = wr && ((m_count < DEPTH) || rd_ok);
      if (rd_ok) check("pop_data", o_rd_data, sb_q.pop_front());
      if (wr_ok) sb_q.push_back(d);
      m_ovf = wr && !wr_ok;
      m_udf = rd && !rd_ok;
      if (wr_ok && !rd_ok) m_count++;
      if (rd_ok && !wr_ok) m_count--;
    end
    @(posedge i_clk);
    #1;
    check("count",     o_count,     m_count);
    check("empty",     o_empty,     m_count == 0);
    check("full",      o_full,      m_count == DEPTH);
    check("overflow",  o_overflow,  m_ovf);
    check("underflow", o_underflow, m_udf);
    if (m_count != 0) check("head", o_rd_data, sb_q[0]);
    else              check("head_zero", o_rd_data, 8'h00);
  endtask

  typedef struct {
    logic       rst_n;
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic [4:0] exp_count;
    logic       exp_udf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    i_reset_n = 1'b0;
    i_write   = 1'b0;
    i_wr_data = '0;
    i_read    = 1'b0;
    @(posedge i_clk);
    #1;

    // Reset, ordered write/read of three words, then empty-FIFO read cases.
    vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h11, 1'b0, 5'd1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'h22, 1'b0, 5'd2, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h33, 1'b0, 5'd3, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd2, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 8'h77, 1'b1, 5'd1, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      do_cycle(vecs[i].rst_n, vecs[i].wr, vecs[i].din, vecs[i].rd);
      check($sformatf("vec%0d_count", i), o_count, vecs[i].exp_count);
      check($sformatf("vec%0d_udf", i), o_underflow, vecs[i].exp_udf);
    end

    // Fill to full, one rejected write, then drain in order.
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b1, 8'(i), 1'b0);
    do_cycle(1'b1, 1'b1, 8'hAA, 1'b0);
    check("ovf_pulse", o_overflow, 1'b1);
    check("full_count", o_count, 5'd16);
    do_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("ovf_single", o_overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Full FIFO with simultaneous push and pop: both accepted, 0x55 comes out last.
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b1, 8'(i), 1'b0);
    do_cycle(1'b1, 1'b1, 8'h55, 1'b1);
    check("both_full_count", o_count, 5'd16);
    check("both_full_no_ovf", o_overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Steady-state streaming at count 3 across pointer wrap.
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1, 8'hC0 + 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      do_cycle(1'b1, 1'b1, 8'h40 + 8'(i), 1'b1);
      check("stream_count", o_count, 5'd3);
    end
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Mid-operation reset with push/pop asserted, then recovery.
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b1, 8'hE0 + 8'(i), 1'b0);
    check("pre_reset_count", o_count, 5'd5);
    do_cycle(1'b0, 1'b1, 8'hFF, 1'b1);
    check("rst_count", o_count, 5'd0);
    check("rst_empty", o_empty, 1'b1);
    check("rst_rd_data", o_rd_data, 8'h00);
    do_cycle(1'b1, 1'b1, 8'h9C, 1'b0);
    check("after_rst_head", o_rd_data, 8'h9C);
    do_cycle(1'b1, 1'b0, 8'h00, 1'b1);

    check("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
